// File: rtl/exec_stage_if.sv
// Instruction, writeback, branch and memory signals of the HybridCore execute stage.
// master: upstream/memory side; slave: the execute stage itself.
interface exec_stage_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_IDX_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_op;
  logic [DATA_W-1:0]    in_a;
  logic [DATA_W-1:0]    in_b;
  logic [REG_IDX_W-1:0] in_dst;

  logic                 wb_valid;
  logic                 wb_we;
  logic [DATA_W-1:0]    wb_result;
  logic [3:0]           wb_nzcv;
  logic [REG_IDX_W-1:0] wb_dst;

  logic                 br_en;
  logic [DATA_W-1:0]    br_target;

  logic                 mem_req;
  logic                 mem_we;
  logic [DATA_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_ack;
  logic [DATA_W-1:0]    mem_rdata;

  modport master (
    output in_valid, in_op, in_a, in_b, in_dst, mem_ack, mem_rdata,
    input  in_ready, wb_valid, wb_we, wb_result, wb_nzcv, wb_dst, br_en, br_target,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_dst, mem_ack, mem_rdata,
    output in_ready, wb_valid, wb_we, wb_result, wb_nzcv, wb_dst, br_en, br_target,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/exec_stage.sv
// HybridCore execute stage: single-cycle ALU/move/flag/branch ops, multi-cycle memory ops.
// Define EXEC_STACK_EN to add the stack pointer and PUSH/POP/CALL/RET; otherwise those are NOPs.
module exec_stage #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       REG_IDX_W = 5,
  parameter logic [DATA_W-1:0] SP_RESET  = {DATA_W{1'b1}}
) (
  input logic         clk,
  input logic         reset,
  exec_stage_if.slave bus
);

  localparam int unsigned ShW = $clog2(DATA_W);
  localparam int unsigned Msb = DATA_W - 1;

  localparam logic [4:0] OpAdd    = 5'b00000;
  localparam logic [4:0] OpAdc    = 5'b00001;
  localparam logic [4:0] OpSub    = 5'b00010;
  localparam logic [4:0] OpSbc    = 5'b00011;
  localparam logic [4:0] OpAnd    = 5'b00100;
  localparam logic [4:0] OpOr     = 5'b00101;
  localparam logic [4:0] OpXor    = 5'b00110;
  localparam logic [4:0] OpNot    = 5'b00111;
  localparam logic [4:0] OpShl    = 5'b01000;
  localparam logic [4:0] OpShr    = 5'b01001;
  localparam logic [4:0] OpAsr    = 5'b01010;
  localparam logic [4:0] OpCmp    = 5'b01011;
  localparam logic [4:0] OpMov    = 5'b10000;
  localparam logic [4:0] OpLoad   = 5'b10010;
  localparam logic [4:0] OpStore  = 5'b10011;
  localparam logic [4:0] OpMsr    = 5'b10100;
  localparam logic [4:0] OpMrs    = 5'b10101;
  localparam logic [4:0] OpPush   = 5'b10110;
  localparam logic [4:0] OpPop    = 5'b10111;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpCall   = 5'b11010;
  localparam logic [4:0] OpRet    = 5'b11011;

  typedef enum logic [1:0] {StIdle, StMem, StDone} state_e;

  state_e               state_q;
  logic [3:0]           nzcv_q;
  logic [4:0]           op_q;
  logic [REG_IDX_W-1:0] dst_q;
  logic                 in_ready_q;
  logic                 wb_valid_q, wb_we_q, br_en_q;
  logic [DATA_W-1:0]    wb_result_q, br_target_q;
  logic [3:0]           wb_nzcv_q;
  logic [REG_IDX_W-1:0] wb_dst_q;
  logic                 mem_req_q, mem_we_q;
  logic [DATA_W-1:0]    mem_addr_q, mem_wdata_q;
`ifdef EXEC_STACK_EN
  logic [DATA_W-1:0]    sp_q;
  logic [DATA_W-1:0]    tgt_q;
`endif

  logic              accept;
  logic [DATA_W-1:0] a, b, b_op, res, maddr;
  logic [ShW-1:0]    sh;
  logic              sub, cin, c_new, v_new;
  logic [DATA_W:0]   sum, shl, shr, asr;
  logic              alu_flags, flag_we, wr, br, is_mem, mwe, cond_ok;
  logic [3:0]        nzcv_new;

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    unique case (bus.in_dst[2:0])
      3'd0:    cond_ok = 1'b1;
      3'd1:    cond_ok = nzcv_q[2];
      3'd2:    cond_ok = ~nzcv_q[2];
      3'd3:    cond_ok = nzcv_q[3] ^ nzcv_q[0];
      3'd4:    cond_ok = ~(nzcv_q[3] ^ nzcv_q[0]);
      3'd5:    cond_ok = nzcv_q[1];
      3'd6:    cond_ok = ~nzcv_q[1];
      default: cond_ok = nzcv_q[3];
    endcase
  end

  always_comb begin
    a    = bus.in_a;
    b    = bus.in_b;
    sh   = b[ShW-1:0];
    sub  = (bus.in_op == OpSub) || (bus.in_op == OpSbc) || (bus.in_op == OpCmp);
    b_op = sub ? ~b : b;
    case (bus.in_op)
      OpAdd:        cin = 1'b0;
      OpSub, OpCmp: cin = 1'b1;
      default:      cin = nzcv_q[1];
    endcase
    // a + b + cin covers ADD/ADC; a + ~b + cin covers SUB/SBC/CMP with C meaning "no borrow".
    sum = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};
    shl = {1'b0, a} << sh;
    shr = {a, 1'b0} >> sh;
    asr = $signed({a, 1'b0}) >>> sh;

    res       = '0;
    c_new     = nzcv_q[1];
    v_new     = nzcv_q[0];
    alu_flags = 1'b0;
    flag_we   = 1'b0;
    nzcv_new  = nzcv_q;
    wr        = 1'b0;
    br        = 1'b0;
    is_mem    = 1'b0;
    mwe       = 1'b0;
    maddr     = b;

    case (bus.in_op)
      OpAdd, OpAdc, OpSub, OpSbc, OpCmp: begin
        res       = sum[Msb:0];
        c_new     = sum[DATA_W];
        v_new     = (a[Msb] == b_op[Msb]) && (sum[Msb] != a[Msb]);
        alu_flags = 1'b1;
        wr        = (bus.in_op != OpCmp);
      end
      OpAnd: begin res = a & b; alu_flags = 1'b1; wr = 1'b1; end
      OpOr:  begin res = a | b; alu_flags = 1'b1; wr = 1'b1; end
      OpXor: begin res = a ^ b; alu_flags = 1'b1; wr = 1'b1; end
      OpNot: begin res = ~a;    alu_flags = 1'b1; wr = 1'b1; end
      OpShl: begin
        res = shl[Msb:0];
        if (sh != '0) c_new = shl[DATA_W];
        v_new = 1'b0; alu_flags = 1'b1; wr = 1'b1;
      end
      OpShr: begin
        res = shr[DATA_W:1];
        if (sh != '0) c_new = shr[0];
        v_new = 1'b0; alu_flags = 1'b1; wr = 1'b1;
      end
      OpAsr: begin
        res = asr[DATA_W:1];
        if (sh != '0) c_new = asr[0];
        v_new = 1'b0; alu_flags = 1'b1; wr = 1'b1;
      end
      OpMov:   begin res = b; wr = 1'b1; end
      OpMsr:   begin nzcv_new = b[3:0]; flag_we = 1'b1; end
      OpMrs:   begin res[3:0] = nzcv_q; wr = 1'b1; end
      OpLoad:  is_mem = 1'b1;
      OpStore: begin is_mem = 1'b1; mwe = 1'b1; end
`ifdef EXEC_STACK_EN
      OpPush, OpCall: begin
        is_mem = 1'b1;
        mwe    = 1'b1;
        maddr  = sp_q - {{(DATA_W-1){1'b0}}, 1'b1};
      end
      OpPop, OpRet: begin
        is_mem = 1'b1;
        maddr  = sp_q;
      end
`endif
      OpBranch: br = cond_ok;
      default: ;
    endcase

    if (alu_flags) begin
      nzcv_new = {res[Msb], res == '0, c_new, v_new};
      flag_we  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      nzcv_q      <= 4'b0;
      op_q        <= 5'b0;
      dst_q       <= '0;
      in_ready_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_result_q <= '0;
      wb_nzcv_q   <= 4'b0;
      wb_dst_q    <= '0;
      br_en_q     <= 1'b0;
      br_target_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef EXEC_STACK_EN
      tgt_q       <= '0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      br_en_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            op_q  <= bus.in_op;
            dst_q <= bus.in_dst;
            if (is_mem) begin
              state_q     <= StMem;
              in_ready_q  <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= mwe;
              mem_addr_q  <= maddr;
              mem_wdata_q <= a;
`ifdef EXEC_STACK_EN
              tgt_q       <= b;
`endif
            end else begin
              wb_valid_q  <= 1'b1;
              wb_we_q     <= wr;
              wb_result_q <= res;
              wb_nzcv_q   <= nzcv_new;
              wb_dst_q    <= bus.in_dst;
              br_en_q     <= br;
              br_target_q <= b;
              if (flag_we) nzcv_q <= nzcv_new;
            end
          end
        end
        StMem: begin
          if (bus.mem_ack) begin
            state_q     <= StDone;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b1;
            wb_we_q     <= (op_q == OpLoad) || (op_q == OpPop);
            wb_result_q <= bus.mem_rdata;
            wb_nzcv_q   <= nzcv_q;
            wb_dst_q    <= dst_q;
`ifdef EXEC_STACK_EN
            if (op_q == OpCall) begin
              br_en_q     <= 1'b1;
              br_target_q <= tgt_q;
            end
            if (op_q == OpRet) begin
              br_en_q     <= 1'b1;
              br_target_q <= bus.mem_rdata;
            end
`endif
          end
        end
        StDone: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef EXEC_STACK_EN
  // SP moves only when the stack access completes, so an aborted access leaves it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= SP_RESET;
    end else if (state_q == StMem && bus.mem_ack) begin
      case (op_q)
        OpPush, OpCall: sp_q <= sp_q - {{(DATA_W-1){1'b0}}, 1'b1};
        OpPop, OpRet:   sp_q <= sp_q + {{(DATA_W-1){1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_result = wb_result_q;
  assign bus.wb_nzcv   = wb_nzcv_q;
  assign bus.wb_dst    = wb_dst_q;
  assign bus.br_en     = br_en_q;
  assign bus.br_target = br_target_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
